// File: rtl/sysid_check_pkg.sv
// Shared types and constants for the sysid check controller and its read engine.
package sysid_check_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned RETRY_W = 4;

  localparam logic ID_ADDR = 1'b0;
  localparam logic TS_ADDR = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ID_REQ  = 3'd1,
    ID_WAIT = 3'd2,
    TS_REQ  = 3'd3,
    TS_WAIT = 3'd4,
    EVAL    = 3'd5,
    FIN     = 3'd6
  } state_t;

endpackage

// File: rtl/sysid_rd_xact.sv
// Single Avalon-MM read handshake: request/address registers plus a per-read timeout counter.
module sysid_rd_xact
  import sysid_check_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic issue,
  input  logic issue_addr,
  input  logic load,
  input  logic active,
  input  logic req_phase,
  input  logic wait_phase,
  input  logic avm_waitrequest,
  input  logic avm_readdatavalid,
  output logic avm_read,
  output logic avm_address,
  output logic accept_c,
  output logic valid_c,
  output logic expire_c
);

  logic [CNT_W-1:0] cnt;

  // Request lines follow the controller's next state, so they are registered yet glitch-free.
  always_ff @(posedge clock) begin
    if (reset) begin
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      cnt         <= '0;
    end else begin
      avm_read    <= issue;
      avm_address <= issue ? issue_addr : 1'b0;
      if (load) begin
        cnt <= '0;
      end else if (active && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Expiry fires in the cycle where the counter would step onto TIMEOUT_CYCLES-1.
  always_comb begin
    accept_c = req_phase & ~avm_waitrequest;
    valid_c  = wait_phase & avm_readdatavalid;
    expire_c = active & (({1'b0, cnt} + 17'd2) >= 17'(TIMEOUT_CYCLES));
  end

endmodule

// File: rtl/sysid_check_ctrl.sv
// Reads the sysid ID and timestamp words over Avalon-MM and compares them with expected values.
// Optional re-check on mismatch is enabled by defining SYSID_CHECK_RETRY_EN.
module sysid_check_ctrl
  import sysid_check_pkg::*;
#(
  parameter logic [31:0] EXP_ID         = 32'h0000_0000,
  parameter logic [31:0] EXP_TS         = 32'd1637742172,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout_err,
  output logic [DATA_W-1:0] id_value,
  output logic [DATA_W-1:0] ts_value,
  output logic [3:0]        retry_cnt,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  input  logic [DATA_W-1:0] avm_readdata
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535) || (MAX_RETRY > 15)) begin : g_param_check
    $error("sysid_check_ctrl: parameter out of range");
  end

  state_t state;
  state_t next_state;

  logic id_match;
  logic ts_match;
  logic issue;
  logic issue_addr;
  logic load;
  logic active;
  logic req_phase;
  logic wait_phase;
  logic accept_c;
  logic valid_c;
  logic expire_c;

`ifdef SYSID_CHECK_RETRY_EN
  logic [RETRY_W-1:0] retry_q;
`endif

  assign id_match = (id_value == EXP_ID);
  assign ts_match = (ts_value == EXP_TS);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the read-engine controls derived from it.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    issue_addr = ID_ADDR;
    load       = 1'b0;
    active     = 1'b0;
    req_phase  = 1'b0;
    wait_phase = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) next_state = ID_REQ;
      end
      ID_REQ: begin
        if (expire_c)      next_state = FIN;
        else if (accept_c) next_state = ID_WAIT;
      end
      ID_WAIT: begin
        if (valid_c)       next_state = TS_REQ;
        else if (expire_c) next_state = FIN;
      end
      TS_REQ: begin
        if (expire_c)      next_state = FIN;
        else if (accept_c) next_state = TS_WAIT;
      end
      TS_WAIT: begin
        if (valid_c)       next_state = EVAL;
        else if (expire_c) next_state = FIN;
      end
      EVAL: begin
        next_state = FIN;
`ifdef SYSID_CHECK_RETRY_EN
        if (!(id_match && ts_match) && (retry_q < RETRY_W'(MAX_RETRY))) next_state = ID_REQ;
`endif
      end
      FIN: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    req_phase  = (state == ID_REQ) || (state == TS_REQ);
    wait_phase = (state == ID_WAIT) || (state == TS_WAIT);
    active     = req_phase || wait_phase;
    issue      = (next_state == ID_REQ) || (next_state == TS_REQ);
    issue_addr = (next_state == TS_REQ) ? TS_ADDR : ID_ADDR;
    load       = ((next_state == ID_REQ) && (state != ID_REQ)) ||
                 ((next_state == TS_REQ) && (state != TS_REQ));
  end

  sysid_rd_xact #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rd_xact (
    .clock             (clock),
    .reset             (reset),
    .issue             (issue),
    .issue_addr        (issue_addr),
    .load              (load),
    .active            (active),
    .req_phase         (req_phase),
    .wait_phase        (wait_phase),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid),
    .avm_read          (avm_read),
    .avm_address       (avm_address),
    .accept_c          (accept_c),
    .valid_c           (valid_c),
    .expire_c          (expire_c)
  );

  // Result registers: cleared on an accepted start, otherwise held for software to read.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= (state == FIN);
      unique case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            pass        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
          end
        end
        ID_REQ, TS_REQ: begin
          if (expire_c) timeout_err <= 1'b1;
        end
        ID_WAIT: begin
          if (valid_c)       id_value    <= avm_readdata;
          else if (expire_c) timeout_err <= 1'b1;
        end
        TS_WAIT: begin
          if (valid_c)       ts_value    <= avm_readdata;
          else if (expire_c) timeout_err <= 1'b1;
        end
        EVAL: begin
          id_ok <= id_match;
          ts_ok <= ts_match;
        end
        FIN: begin
          busy <= 1'b0;
          pass <= id_ok & ts_ok & ~timeout_err;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYSID_CHECK_RETRY_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      retry_q <= '0;
    end else if ((state == IDLE) && start) begin
      retry_q <= '0;
    end else if ((state == EVAL) && (next_state == ID_REQ)) begin
      retry_q <= retry_q + RETRY_W'(1);
    end
  end

  assign retry_cnt = retry_q;
`else
  assign retry_cnt = '0;
`endif

endmodule

// File: doc/sysid_check_ctrl.md
SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- EXP_ID, 32'h0000_0000, expected system ID word (address 0).
- EXP_TS, 32'd1637742172, expected timestamp word (address 1).
- TIMEOUT_CYCLES, 1024, maximum cycles allowed per read transaction (16-bit counter, range 1..65535).
- MAX_RETRY, 3, extra check passes allowed after a mismatch (range 0..15; used only when SYSID_CHECK_RETRY_EN is defined).
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clock, in, 1, single clock.
- reset, in, 1, synchronous, active-high.
- start, in, 1, single-cycle request to begin a check.
- busy, out, 1, high from acceptance of start to done.
- done, out, 1, one-cycle pulse at completion.
- pass, out, 1, id_ok AND ts_ok AND NOT timeout_err.
- id_ok, out, 1, captured ID equals EXP_ID.
- ts_ok, out, 1, captured timestamp equals EXP_TS.
- timeout_err, out, 1, a read exceeded TIMEOUT_CYCLES.
- id_value, out, 32, last captured ID word.
- ts_value, out, 32, last captured timestamp word.
- retry_cnt, out, 4, retries consumed in the last check.
- avm_address, out, 1, Avalon-MM word address to the sysid slave.
- avm_read, out, 1, Avalon-MM read request.
- avm_waitrequest, in, 1, slave stall.
- avm_readdatavalid, in, 1, read data valid.
- avm_readdata, in, 32, read data.

Function
REQ-003 The FSM SHALL have the states IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT, EVAL and FIN.
REQ-004 In IDLE, start=1 SHALL move to ID_REQ on the next edge, set busy, and clear id_ok, ts_ok, timeout_err, pass and retry_cnt; start while busy SHALL be ignored.
REQ-005 In ID_REQ, avm_read=1 and avm_address=0 SHALL be held until a cycle with avm_waitrequest=0, which accepts the read and moves to ID_WAIT.
REQ-006 In ID_WAIT, avm_read SHALL be 0; avm_readdatavalid=1 SHALL capture avm_readdata into id_value and move to TS_REQ.
REQ-007 TS_REQ and TS_WAIT SHALL behave as ID_REQ and ID_WAIT, but with avm_address=1 and capture into ts_value, then move to EVAL.
REQ-008 avm_readdatavalid SHALL be ignored outside the *_WAIT states; readdatavalid coincident with acceptance SHALL NOT be taken.
REQ-009 A 16-bit timeout counter SHALL clear on entry to each *_REQ state and increment in *_REQ/*_WAIT; when it reaches TIMEOUT_CYCLES-1 without completion, timeout_err SHALL be set, avm_read dropped, and the FSM SHALL go to FIN.
REQ-010 EVAL SHALL last one cycle, registering id_ok=(id_value==EXP_ID) and ts_ok=(ts_value==EXP_TS), then go to FIN (retry per REQ-015).
REQ-011 FIN SHALL pulse done for exactly one cycle, clear busy, and return to IDLE.
REQ-012 Latency from start to done SHALL be 6 cycles with zero waitrequest and readdatavalid one cycle after acceptance.
REQ-013 id_ok, ts_ok, pass, timeout_err, id_value, ts_value and retry_cnt SHALL hold until the next accepted start.

Reset
REQ-014 reset SHALL force IDLE and drive every output to 0 (busy, done, pass, id_ok, ts_ok, timeout_err, id_value, ts_value, retry_cnt, avm_read, avm_address); reset mid-transaction SHALL abandon it, and a late readdatavalid SHALL be ignored.

Configuration
REQ-015 With SYSID_CHECK_RETRY_EN defined, an EVAL mismatch with retry_cnt<MAX_RETRY SHALL increment retry_cnt and return to ID_REQ; a timeout SHALL never retry.
REQ-016 Without SYSID_CHECK_RETRY_EN, EVAL SHALL always go to FIN, retry_cnt SHALL be tied to 0, and MAX_RETRY SHALL be unused.

Structure
REQ-017 Package sysid_check_pkg SHALL hold the state enum, the address constants (ID_ADDR=0, TS_ADDR=1) and the counter width constant.
REQ-018 The single-read handshake plus timeout SHALL be sub-module sysid_rd_xact, instantiated once and address-multiplexed by the FSM.

Verification
REQ-019 Zero-stall slave returning 0 and 1637742172 -> done at cycle 6, pass=1, id_value=0, ts_value=1637742172.
REQ-020 waitrequest held for 5 cycles on the ID read -> avm_read stays high and stable for 6 cycles, then pass=1 and done at cycle 11.
REQ-021 No readdatavalid with TIMEOUT_CYCLES=8 -> timeout_err=1, pass=0, done 8 cycles after the ID_REQ entry, avm_read=0.
REQ-022 Timestamp read returns 0 with RETRY_EN and MAX_RETRY=2 -> three passes, retry_cnt=2, ts_ok=0, pass=0; without the macro -> one pass, retry_cnt=0.
REQ-023 reset asserted in TS_WAIT, then a stray readdatavalid -> all outputs 0, remains in IDLE, no done pulse.
REQ-024 start pulsed while busy -> ignored, exactly one done pulse.
